ysyx_23060077_riscv_axi_sram: RTL and testbench
===============================================

# ysyx_23060077_riscv_axi_sram

AXI4-Lite slave memory that sits directly downstream of the core's AXI arbiter and serves both instruction fetches and load/store traffic. It holds a word-addressed SRAM array, accepts one transaction at a time, applies a configurable response latency, and returns read data or a write acknowledgement. The latency exercises the IFU/LSU stall paths.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (strobe width = DATA_WIDTH/8)
- DEPTH_LOG2, 16, log2 of array depth in words
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0
- LATENCY, 1, wait cycles between request acceptance and response (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- arvalid  in  1  read address valid
- araddr  in  ADDR_WIDTH  read byte address
- arready  out  1  read address accepted
- rvalid  out  1  read data valid
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rready  in  1  master accepts read data
- awvalid  in  1  write address valid
- awaddr  in  ADDR_WIDTH  write byte address
- awready  out  1  write address accepted
- wvalid  in  1  write data valid
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wready  out  1  write data accepted
- bvalid  out  1  write response valid
- bresp  out  2  write response
- bready  in  1  master accepts write response

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- arready = (state==IDLE). awready = wready = (state==IDLE) & !arvalid & awvalid & wvalid; AW and W always accepted together, in the same cycle.
- Simultaneous read and write request in IDLE: read wins; write stays pending and is accepted on the next return to IDLE.
- On acceptance: capture address (and wdata/wstrb), load delay counter, go to RD_WAIT / WR_WAIT.
- RD_WAIT/WR_WAIT: counter decrements each cycle; at 0 go to RD_RESP / WR_RESP.
- Index = (addr − BASE_ADDR) >> 2, low DEPTH_LOG2 bits; addr[1:0] ignored. In range iff (addr − BASE_ADDR) < 4·2^DEPTH_LOG2 (unsigned).
- Read: on WAIT→RESP transition, rdata ← mem[index], rresp = 2'b00; out of range: rdata = 0, rresp = 2'b10.
- Write: on WAIT→RESP transition, each byte i with wstrb[i]=1 is written; bresp = 2'b00. Out of range: no write, bresp = 2'b10.
- RD_RESP holds rvalid/rdata/rresp stable until rvalid&rready, then IDLE. WR_RESP likewise with bvalid/bready.
- Memory contents are not reset; uninitialised reads return array contents (X in simulation).

## Timing
- Reset: state IDLE, counter 0, rvalid=bvalid=0, rdata=0, rresp=bresp=0; arready=1 combinationally once rst_n high. Assertion mid-transaction aborts it immediately (valids drop asynchronously); a pending write in WR_WAIT is discarded.
- Read accepted at cycle T: rvalid high from T+1+LATENCY. LATENCY=0 gives rvalid at T+1.
- Write accepted at T: array updated and bvalid high from T+1+LATENCY.
- Handshake completes at cycle C: state is IDLE at C+1; a new request may be accepted at C+1 (minimum one idle cycle between transactions).
- Read after write to the same address returns the new data (write committed before bvalid).

## Configuration
- YSYX_23060077_SRAM_RAND_DELAY_EN defined: delay counter loaded with lfsr[3:0] instead of LATENCY. LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle regardless of traffic.
- Undefined: fixed LATENCY delay, no LFSR logic present.

## Test plan
- Reset, LATENCY=1: write 32'hDEAD_BEEF, wstrb=4'hF to 32'h8000_0010 -> bvalid at T+2, bresp=0; read same -> rvalid at T+2, rdata=32'hDEAD_BEEF.
- Partial strobe: after above, write 32'h0000_5500 with wstrb=4'b0010 -> read returns 32'hDEAD_55EF.
- Simultaneous arvalid and awvalid+wvalid in IDLE -> read accepted first, awready=0 that cycle; write accepted one cycle after read handshake completes.
- Backpressure: rready held low 5 cycles after rvalid -> rvalid and rdata stable throughout, arready=0; after handshake IDLE next cycle.
- Out of range: read 32'h7FFF_FFFC -> rresp=2'b10, rdata=0; write 32'h8004_0000 (DEPTH_LOG2=16) -> bresp=2'b10, array unchanged.
- rst_n pulsed low during WR_WAIT -> bvalid stays 0, write discarded, arready=1 after release.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_sram.sv
// AXI4-Lite slave SRAM with one outstanding transaction and a programmable response delay.
// Define YSYX_23060077_SRAM_RAND_DELAY_EN to draw each delay from a free-running 16-bit LFSR instead of LATENCY.
module ysyx_23060077_riscv_axi_sram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arvalid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    input  logic                    rready,
    input  logic                    awvalid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awready,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wready,
    output logic                    bvalid,
    output logic [1:0]              bresp,
    input  logic                    bready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [3:0]              delay;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [STRB_W-1:0]       acc_wstrb;
    logic [ADDR_WIDTH-1:0]   off;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    in_range;
    logic                    do_rd;
    logic                    do_wr;
    logic                    mem_we;
    logic                    unused_off_bits;

`ifdef YSYX_23060077_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci taps 16,14,13,11; free-running so the delay is independent of traffic.
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end

    assign delay = lfsr_q[3:0];
`else
    assign delay = 4'(LATENCY);
`endif

    assign arready = rst_n && (state_q == IDLE);
    assign awready = rst_n && (state_q == IDLE) && !arvalid && awvalid && wvalid;
    assign wready  = awready;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        do_rd     = 1'b0;
        do_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                // Read has priority; a concurrent write simply waits for the next IDLE.
                if (arvalid) begin
                    addr_d = araddr;
                    if (delay == 4'd0) begin
                        acc_addr = araddr;
                        do_rd    = 1'b1;
                        state_d  = RD_RESP;
                    end else begin
                        cnt_d   = delay;
                        state_d = RD_WAIT;
                    end
                end else if (awvalid && wvalid) begin
                    addr_d  = awaddr;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (delay == 4'd0) begin
                        acc_addr  = awaddr;
                        acc_wdata = wdata;
                        acc_wstrb = wstrb;
                        do_wr     = 1'b1;
                        state_d   = WR_RESP;
                    end else begin
                        cnt_d   = delay;
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    do_rd   = 1'b1;
                    state_d = RD_RESP;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    do_wr   = 1'b1;
                    state_d = WR_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        off             = acc_addr - BASE_ADDR;
        idx             = off[DEPTH_LOG2+1:2];
        in_range        = (off >> (DEPTH_LOG2 + 2)) == '0;
        unused_off_bits = ^off[1:0];

        if (do_rd) begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? mem[idx] : '0;
            rresp_d  = in_range ? 2'b00 : 2'b10;
        end
        if (do_wr) begin
            bvalid_d = 1'b1;
            bresp_d  = in_range ? 2'b00 : 2'b10;
        end
    end

    // Gated by rst_n so an edge seen while reset is held can never commit a write.
    assign mem_we = do_wr && in_range && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_sram.sv
// Directed bench for the AXI4-Lite SRAM: drivers push expected responses, a negedge monitor pops and checks them.
module tb_ysyx_23060077_riscv_axi_sram;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = 0;

  logic [33:0] exp_rq[$];
  logic [1:0]  exp_bq[$];

  ysyx_23060077_riscv_axi_sram dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_rq.size() == 0) chk("unexpected_read_resp", 64'd1, 64'd0);
      else begin
        logic [33:0] e;
        e = exp_rq.pop_front();
        chk("rdata", {32'd0, rdata}, {32'd0, e[31:0]});
        chk("rresp", {62'd0, rresp}, {62'd0, e[33:32]});
        hs_cyc = cyc;
      end
    end
    if (rst_n && bvalid && bready) begin
      if (exp_bq.size() == 0) chk("unexpected_write_resp", 64'd1, 64'd0);
      else begin
        logic [1:0] e;
        e = exp_bq.pop_front();
        chk("bresp", {62'd0, bresp}, {62'd0, e});
      end
    end
  end

  task automatic wait_neg_until_rvalid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!rvalid) chk("rvalid_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_neg_until_bvalid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!bvalid) chk("bvalid_timeout", 64'd1, 64'd0);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp);
    int n;
    int lat;
    exp_bq.push_back(exp_resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) chk("awready_timeout", 64'd1, 64'd0);
    chk("wready_with_awready", {63'd0, wready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_neg_until_bvalid(lat);
    chk("bvalid_latency", 64'(lat), 64'(LAT + 1));
    @(posedge clk); #1;
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                          input int hold);
    int n;
    int lat;
    exp_rq.push_back({exp_resp, exp_d});
    if (hold > 0) rready = 1'b0;
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) chk("arready_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_neg_until_rvalid(lat);
    chk("rvalid_latency", 64'(lat), 64'(LAT + 1));
    for (int i = 0; i < hold; i++) begin
      chk("bp_rvalid_stable", {63'd0, rvalid}, 64'd1);
      chk("bp_rdata_stable", {32'd0, rdata}, {32'd0, exp_d});
      chk("bp_arready_low", {63'd0, arready}, 64'd0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_read_hs", {63'd0, arready}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int n;
    rst_n = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_arready", {63'd0, arready}, 64'd1);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_rresp", {62'd0, rresp}, 64'd0);
    chk("rst_bresp", {62'd0, bresp}, 64'd0);
    @(posedge clk); #1;

    // basic write/read and partial strobe
    write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    read_txn(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
    write_txn(32'h8000_0010, 32'h0000_5500, 4'b0010, 2'b00);
    read_txn(32'h8000_0012, 32'hDEAD_55EF, 2'b00, 0);

    // simultaneous read and write: read wins, write accepted the cycle after the read handshake
    write_txn(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 2'b00);
    exp_rq.push_back({2'b00, 32'hCAFE_F00D});
    exp_bq.push_back(2'b00);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    awaddr = 32'h8000_0020; wdata = 32'h1122_3344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("sim_arready", {63'd0, arready}, 64'd1);
    chk("sim_awready", {63'd0, awready}, 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_neg_until_rvalid(lat);
    chk("sim_rvalid_latency", 64'(lat), 64'(LAT + 1));
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("sim_write_accept_cycle", 64'(cyc), 64'(hs_cyc + 1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_neg_until_bvalid(lat);
    chk("sim_bvalid_latency", 64'(lat), 64'(LAT + 1));
    @(posedge clk); #1;
    read_txn(32'h8000_0020, 32'h1122_3344, 2'b00, 0);

    // backpressure on R channel
    read_txn(32'h8000_0010, 32'hDEAD_55EF, 2'b00, 5);

    // out of range, including an address that would alias to word 0
    write_txn(32'h8000_0000, 32'h0BAD_C0DE, 4'hF, 2'b00);
    read_txn(32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 0);
    write_txn(32'h8004_0000, 32'hFFFF_FFFF, 4'hF, 2'b10);
    read_txn(32'h8000_0000, 32'h0BAD_C0DE, 2'b00, 0);

    // reset during WR_WAIT discards the write
    awaddr = 32'h8000_0010; wdata = 32'h9999_9999; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("abort_awready", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bvalid_low", {63'd0, bvalid}, 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_bvalid_in_reset", {63'd0, bvalid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_arready", {63'd0, arready}, 64'd1);
    chk("abort_bvalid_after", {63'd0, bvalid}, 64'd0);
    @(posedge clk); #1;
    read_txn(32'h8000_0010, 32'hDEAD_55EF, 2'b00, 0);

    repeat (3) @(posedge clk);
    chk("read_queue_drained", 64'(exp_rq.size()), 64'd0);
    chk("write_queue_drained", 64'(exp_bq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
